twoway_32bit_demux: RTL and testbench
=====================================

Name: twoway_32bit_demux

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the counterpart of the two-way 32-bit select mux.
- Steers a single 32-bit word stream (e.g. autocorrelation / windowing results) to one of two consumers, such as the two LPC-stage memory write ports.
- Each output has a one-deep holding register and a handshake word counter.
- Sits between the autocorrelation datapath and downstream storage/consumers.

Parameters:
DATA_W  32  width of data words
CNT_W   16  width of per-output transfer counters

Ports:
clk         input   1        system clock, rising edge
reset       input   1        asynchronous, active-low reset
clear       input   1        synchronous clear, active-high
in_data     input   DATA_W   input word
in_sel      input   1        destination: 0 -> out0, 1 -> out1
in_valid    input   1        input word valid
in_ready    output  1        block can accept the word on in_data this cycle
out0_data   output  DATA_W   output 0 word
out0_valid  output  1        output 0 word valid
out0_ready  input   1        consumer 0 accepts
out1_data   output  DATA_W   output 1 word
out1_valid  output  1        output 1 word valid
out1_ready  input   1        consumer 1 accepts
cnt0        output  CNT_W    words delivered on out0
cnt1        output  CNT_W    words delivered on out1

Behaviour:
- Reset (reset=0, asynchronous, any time): out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0.
  - Reset mid-transfer discards held words.
- in_ready is combinational:
  - in_sel=0: in_ready = !clear && (!out0_valid || out0_ready).
  - in_sel=1: same expression using out1.
  - Zero-bubble: a full slot being drained this cycle still accepts.
- Accept = in_valid && in_ready.
  - On that edge, in_data loads into the selected output register and its valid is set.
  - Latency: 1 cycle from accept to outK_valid.
- in_sel and in_data must be held stable while in_valid=1 and in_ready=0. The source may change them only after accept.
- Output K handshake = outK_valid && outK_ready. Same-edge outcomes:
  - Handshake, no load to K: outK_valid clears.
  - Handshake plus load to K: outK_valid stays 1, data replaced with new word.
  - Load with no handshake: only possible when the slot is empty.
- outK_data is stable while outK_valid=1 and outK_ready=0.
- The non-selected output is never disturbed by an accept.
- cntK increments by 1 on each output K handshake.
  - Wraps from 2^CNT_W-1 to 0; no saturation, no flag.
  - Both counters may increment on the same edge.
- clear=1 (synchronous):
  - Next edge: both valids=0, both counters=0. Data registers keep their contents.
  - in_ready=0 while clear=1, so clear has priority over accept.
  - Counter increments on the clear edge are lost.
- outK_ready is ignored when outK_valid=0.
- No state machine beyond the per-output full/empty bit. Each output is an independent 2-state slot (EMPTY, FULL):
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on handshake without load.
  - FULL -> FULL on handshake with load.

Optional Feature:
- Macro TWOWAY_DEMUX_ALTERNATE_EN.
- When defined:
  - Extra input port alt_mode (1 bit), placed after in_sel.
  - Internal toggle bit tgl: reset to 0, cleared to 0 by clear, inverted on every accept while alt_mode=1.
  - While alt_mode=1, tgl replaces in_sel for both the in_ready computation and the steering; in_sel is ignored. Words go out0, out1, out0, ...
  - While alt_mode=0, in_sel steers and tgl holds its value.
- When undefined: no alt_mode port, no toggle register; in_sel always steers.

Test Plan:
- Reset release, in_valid=1, in_sel=0, in_data=32'h12345678, out0_ready=0 -> next cycle out0_valid=1, out0_data=32'h12345678; out1_valid stays 0; in_ready=0 for in_sel=0, 1 for in_sel=1.
- Back-pressure: out0 full with 32'hA, out0_ready=0 for 3 cycles -> data stays 32'hA, in_ready(sel=0)=0. Then out0_ready=1 with in_data=32'hB offered -> same edge accepts; out0_valid stays 1, data=32'hB, cnt0=1.
- Interleave: send 32'h1 (sel 0), 32'h2 (sel 1), 32'h3 (sel 0), both readys=1 -> out0 receives 1 then 3, out1 receives 2; cnt0=2, cnt1=1; one word per cycle, no bubbles.
- Wrap and clear: with CNT_W=4, perform 17 out1 handshakes -> cnt1=1. Assert clear for 1 cycle with both outputs full -> both valids=0, cnt0=cnt1=0, in_ready=0 during clear.
- Async reset: pulse reset low mid-cycle while out1_valid=1 -> outputs clear immediately without waiting for clk; no handshake counted.
- With TWOWAY_DEMUX_ALTERNATE_EN: alt_mode=1, in_sel=1 held, send 4 words 10,11,12,13 -> out0 receives 10,12; out1 receives 11,13.

Source files
------------

// File: rtl/twoway_32bit_demux.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes and per-output transfer counters.
// Optional alternating steering is enabled with the TWOWAY_DEMUX_ALTERNATE_EN macro.
module twoway_32bit_demux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
`ifdef TWOWAY_DEMUX_ALTERNATE_EN
    input  logic              alt_mode,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t slot0_q, slot0_d;
    slot_t slot1_q, slot1_d;

    logic sel_eff;
    logic accept;
    logic load0, load1;
    logic hs0, hs1;

`ifdef TWOWAY_DEMUX_ALTERNATE_EN
    logic tgl;

    // In alternate mode the toggle replaces in_sel for both ready and steering.
    assign sel_eff = alt_mode ? tgl : in_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgl <= 1'b0;
        end else if (clear) begin
            tgl <= 1'b0;
        end else if (accept && alt_mode) begin
            tgl <= ~tgl;
        end
    end
`else
    assign sel_eff = in_sel;
`endif

    assign out0_valid = (slot0_q == FULL);
    assign out1_valid = (slot1_q == FULL);

    assign hs0 = out0_valid && out0_ready;
    assign hs1 = out1_valid && out1_ready;

    // A full slot that drains this cycle still accepts (zero-bubble).
    assign in_ready = !clear && (sel_eff ? (!out1_valid || out1_ready)
                                         : (!out0_valid || out0_ready));

    assign accept = in_valid && in_ready;
    assign load0  = accept && !sel_eff;
    assign load1  = accept &&  sel_eff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0_q <= EMPTY;
            slot1_q <= EMPTY;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    always_comb begin
        slot0_d = slot0_q;
        if (clear) begin
            slot0_d = EMPTY;
        end else begin
            case (slot0_q)
                EMPTY: if (load0)         slot0_d = FULL;
                FULL:  if (hs0 && !load0) slot0_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        slot1_d = slot1_q;
        if (clear) begin
            slot1_d = EMPTY;
        end else begin
            case (slot1_q)
                EMPTY: if (load1)         slot1_d = FULL;
                FULL:  if (hs1 && !load1) slot1_d = EMPTY;
            endcase
        end
    end

    // Data registers survive clear; only valids and counters are wiped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out0_data <= '0;
            out1_data <= '0;
        end else begin
            if (load0) out0_data <= in_data;
            if (load1) out1_data <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (clear) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (hs0) cnt0 <= cnt0 + CNT_W'(1);
            if (hs1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_twoway_32bit_demux.sv
// Self-checking bench for twoway_32bit_demux: per-cycle vector table plus directed
// sequences for counter wrap, clear, asynchronous reset and optional alternate mode.
module tb_twoway_32bit_demux;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;
`ifdef TWOWAY_DEMUX_ALTERNATE_EN
    logic              alt_mode;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    twoway_32bit_demux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_sel     (in_sel),
`ifdef TWOWAY_DEMUX_ALTERNATE_EN
        .alt_mode   (alt_mode),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    typedef struct {
        logic        vld;
        logic        sel;
        logic [31:0] data;
        logic        r0;
        logic        r1;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
        logic [3:0]  e_c0;
        logic [3:0]  e_c1;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v0, input logic [31:0] d0,
                              input logic v1, input logic [31:0] d1,
                              input logic [3:0] c0, input logic [3:0] c1);
        check({tag, " out0_valid"}, 32'(out0_valid), 32'(v0));
        check({tag, " out0_data"},  out0_data, d0);
        check({tag, " out1_valid"}, 32'(out1_valid), 32'(v1));
        check({tag, " out1_data"},  out1_data, d1);
        check({tag, " cnt0"},       32'(cnt0), 32'(c0));
        check({tag, " cnt1"},       32'(cnt1), 32'(c1));
    endtask

    task automatic drive(input logic vld, input logic sel, input logic [31:0] data,
                         input logic r0, input logic r1);
        in_valid   = vld;
        in_sel     = sel;
        in_data    = data;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    initial begin
        //            vld sel data          r0 r1 rdy v0 d0            v1 d1     c0 c1
        vecs[0]  = '{1, 0, 32'h12345678, 0, 0, 1, 1, 32'h12345678, 0, 32'h0, 0, 0};
        vecs[1]  = '{0, 0, 32'h0,        0, 0, 0, 1, 32'h12345678, 0, 32'h0, 0, 0};
        vecs[2]  = '{0, 1, 32'h0,        0, 0, 1, 1, 32'h12345678, 0, 32'h0, 0, 0};
        vecs[3]  = '{1, 0, 32'hA,        1, 0, 1, 1, 32'hA,        0, 32'h0, 1, 0};
        vecs[4]  = '{1, 0, 32'hB,        0, 0, 0, 1, 32'hA,        0, 32'h0, 1, 0};
        vecs[5]  = '{1, 0, 32'hB,        0, 0, 0, 1, 32'hA,        0, 32'h0, 1, 0};
        vecs[6]  = '{1, 0, 32'hB,        0, 0, 0, 1, 32'hA,        0, 32'h0, 1, 0};
        vecs[7]  = '{1, 0, 32'hB,        1, 0, 1, 1, 32'hB,        0, 32'h0, 2, 0};
        vecs[8]  = '{0, 0, 32'h0,        1, 0, 1, 0, 32'hB,        0, 32'h0, 3, 0};
        vecs[9]  = '{1, 0, 32'h1,        1, 1, 1, 1, 32'h1,        0, 32'h0, 3, 0};
        vecs[10] = '{1, 1, 32'h2,        1, 1, 1, 0, 32'h1,        1, 32'h2, 4, 0};
        vecs[11] = '{1, 0, 32'h3,        1, 1, 1, 1, 32'h3,        0, 32'h2, 4, 1};
        vecs[12] = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h3,        0, 32'h2, 5, 1};

        reset = 1'b0;
        clear = 1'b0;
`ifdef TWOWAY_DEMUX_ALTERNATE_EN
        alt_mode = 1'b0;
`endif
        drive(0, 0, 32'h0, 0, 0);
        #2;
        check_outs("reset", 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1);
            #1;
            check({tag, " in_ready"}, 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check_outs(tag, vecs[i].e_v0, vecs[i].e_d0, vecs[i].e_v1, vecs[i].e_d1,
                       vecs[i].e_c0, vecs[i].e_c1);
        end

        // Clear with empty slots zeroes counters.
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0);
        clear = 1'b1;
        #1;
        check("clr_empty in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check_outs("clr_empty", 0, 32'h3, 0, 32'h2, 0, 0);
        @(negedge clk);
        clear = 1'b0;

        // 17 back-to-back out1 handshakes wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(1, 1, 32'(100 + i), 0, 1);
        end
        @(negedge clk);
        drive(0, 1, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        check_outs("wrap", 0, 32'h3, 0, 32'd116, 0, 1);

        // Clear while both slots are full: valids and counters drop, data kept.
        @(negedge clk);
        drive(1, 0, 32'hAA, 0, 0);
        @(negedge clk);
        drive(1, 1, 32'hBB, 0, 0);
        @(posedge clk);
        #1;
        check_outs("full_both", 1, 32'hAA, 1, 32'hBB, 0, 1);
        @(negedge clk);
        drive(1, 0, 32'hCC, 1, 1);
        clear = 1'b1;
        #1;
        check("clr_full in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check_outs("clr_full", 0, 32'hAA, 0, 32'hBB, 0, 0);
        @(negedge clk);
        clear = 1'b0;
        drive(0, 0, 32'h0, 0, 0);

        // Asynchronous reset while out1 holds a word.
        @(negedge clk);
        drive(1, 1, 32'h77, 0, 1);
        @(negedge clk);
        drive(1, 1, 32'h55, 0, 1);
        @(negedge clk);
        drive(0, 1, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("pre_areset", 0, 32'hAA, 1, 32'h55, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        check_outs("areset", 0, 32'h0, 0, 32'h0, 0, 0);
        #1;
        reset = 1'b1;

`ifdef TWOWAY_DEMUX_ALTERNATE_EN
        // Alternate mode ignores in_sel=1 and ping-pongs starting at out0.
        alt_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 1, 32'(10 + i), 1, 1);
            #1;
            check($sformatf("alt%0d in_ready", i), 32'(in_ready), 32'h1);
            @(posedge clk);
            #1;
            if (i % 2 == 0) begin
                check($sformatf("alt%0d out0_data", i), out0_data, 32'(10 + i));
                check($sformatf("alt%0d out0_valid", i), 32'(out0_valid), 32'h1);
            end else begin
                check($sformatf("alt%0d out1_data", i), out1_data, 32'(10 + i));
                check($sformatf("alt%0d out1_valid", i), 32'(out1_valid), 32'h1);
            end
        end
        @(negedge clk);
        drive(0, 1, 32'h0, 1, 1);
        alt_mode = 1'b0;
        @(posedge clk);
        #1;
        check_outs("alt_end", 0, 32'd12, 0, 32'd13, 2, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
